// File: rtl/press_classifier_if.sv
// Button event bundle: debounced level/tick toward the classifier and the
// one-clock event pulses plus busy coming back.
interface press_classifier_if;
  logic db_level;
  logic db_tick;
  logic short_tick;
  logic double_tick;
  logic long_tick;
  logic repeat_tick;
  logic busy;

  modport master (
    output db_level, db_tick,
    input  short_tick, double_tick, long_tick, repeat_tick, busy
  );

  modport slave (
    input  db_level, db_tick,
    output short_tick, double_tick, long_tick, repeat_tick, busy
  );
endinterface

// File: rtl/press_classifier.sv
// Classifies debounced button presses into short, double, long and auto-repeat
// one-clock pulses using a single shared timing counter.
module press_classifier #(
  parameter int CNT_W      = 16,
  parameter int LONG_CYC   = 25000,
  parameter int REPEAT_CYC = 10000,
  parameter int DCLICK_CYC = 12500
) (
  input  logic              clk,
  input  logic              reset_n,
  press_classifier_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             short_reg, short_next;
  logic             double_reg, double_next;
  logic             long_reg, long_next;
  logic             repeat_reg, repeat_next;
  logic             busy_reg, busy_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      short_reg  <= 1'b0;
      double_reg <= 1'b0;
      long_reg   <= 1'b0;
      repeat_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      short_reg  <= short_next;
      double_reg <= double_next;
      long_reg   <= long_next;
      repeat_reg <= repeat_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    short_next  = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (bus.db_tick) begin
          state_next = PRESS1;
        end
      end
      PRESS1: begin
        if (!bus.db_level) begin
          state_next = WAIT2;
          cnt_next   = '0;
        end else if (cnt_reg == LONG_LAST) begin
          state_next = LONG;
          cnt_next   = '0;
          long_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      LONG: begin
        if (!bus.db_level) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == REPEAT_LAST) begin
          cnt_next    = '0;
          repeat_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT2: begin
        // A second press on the timeout edge still counts as a double click.
        if (bus.db_tick) begin
          state_next  = PRESS2;
          cnt_next    = '0;
          double_next = 1'b1;
        end else if (cnt_reg == DCLICK_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          short_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PRESS2: begin
        cnt_next = '0;
        if (!bus.db_level) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign bus.short_tick  = short_reg;
  assign bus.double_tick = double_reg;
  assign bus.long_tick   = long_reg;
  assign bus.repeat_tick = repeat_reg;
  assign bus.busy        = busy_reg;

endmodule
